// File: rtl/btb_update_queue_pkg.sv
// Shared definitions for the BTB write-side update path.
package btb_update_queue_pkg;

   localparam int unsigned ADDR                   = 32;
   localparam int unsigned BTB_UPDATE_QUEUE_DEPTH = 8;

   typedef struct packed {
      logic            valid;
      logic [ADDR-1:0] pc;
      logic [ADDR-1:0] target;
   } BTB_UPDATE_ENTRY;

endpackage

// File: rtl/btb_update_match.sv
// CAM compare of one resolved PC against every queued update entry.
// The head is not a candidate while it is being written out this cycle.
module btb_update_match
   import btb_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH = BTB_UPDATE_QUEUE_DEPTH
) (
   input  BTB_UPDATE_ENTRY [DEPTH-1:0]         entries_i,
   input  logic            [$clog2(DEPTH)-1:0] head_i,
   input  logic                                deq_i,
   input  logic            [ADDR-1:0]          pc_i,
   output logic            [DEPTH-1:0]         hit_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   always_comb begin
      hit_o = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (entries_i[k].valid && (entries_i[k].pc == pc_i) &&
             !(deq_i && (PW'(k) == head_i))) begin
            hit_o[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/btb_update_queue.sv
// Coalescing circular queue between branch resolution and the BTB write port.
// Drains one update per cycle; absorbs multi-lane bursts and merges repeat PCs.
module btb_update_queue
   import btb_update_queue_pkg::*;
#(
   parameter int unsigned DEPTH       = BTB_UPDATE_QUEUE_DEPTH,
   parameter int unsigned NUM_RESOLVE = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_RESOLVE-1:0]       resolve_valid_i,
   input  logic [NUM_RESOLVE-1:0]       resolve_taken_i,
   input  logic [ADDR-1:0]              resolve_pc_i     [NUM_RESOLVE],
   input  logic [ADDR-1:0]              resolve_target_i [NUM_RESOLVE],
   output logic                         wr_en_o,
   output logic [ADDR-1:0]              wr_pc_o,
   output logic [ADDR-1:0]              wr_target_o,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
   output logic [15:0]                  drop_count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned OW = $clog2(DEPTH+1);
   localparam int unsigned DW = 16;

   BTB_UPDATE_ENTRY [DEPTH-1:0] entry_q, entry_d;
   logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
   logic [OW-1:0]               occ_q, occ_d;
   logic [DW-1:0]               drop_q, drop_d;
   logic                        wr_en_q;
   logic [ADDR-1:0]             wr_pc_q, wr_target_q;

   logic                        deq_c;
   logic [NUM_RESOLVE-1:0]      qual_c;
   logic [DEPTH-1:0]            hit_c   [NUM_RESOLVE];
   logic [PW-1:0]               slot_c  [NUM_RESOLVE];
   logic                        alloc_c [NUM_RESOLVE];
   logic                        dup_c;
   logic [OW-1:0]               free_c, enq_c;
   logic [DW-1:0]               ndrop_c;
   logic [DW:0]                 drop_sum_c;
   logic                        wr_valid_c;

   assign deq_c  = (occ_q != '0);
   assign qual_c = resolve_valid_i & resolve_taken_i;

   for (genvar g = 0; g < NUM_RESOLVE; g++) begin : g_match
      btb_update_match #(.DEPTH(DEPTH)) u_match (
         .entries_i (entry_q),
         .head_i    (head_q),
         .deq_i     (deq_c),
         .pc_i      (resolve_pc_i[g]),
         .hit_o     (hit_c[g])
      );
   end

   // Lane-order enqueue: CAM hit, then same-cycle duplicate, then new slot or drop.
   always_comb begin
      entry_d = entry_q;
      head_d  = head_q;
      enq_c   = '0;
      ndrop_c = '0;
      dup_c   = 1'b0;
      free_c  = OW'(DEPTH) - occ_q;
      for (int unsigned i = 0; i < NUM_RESOLVE; i++) begin
         alloc_c[i] = 1'b0;
         slot_c[i]  = '0;
      end

      if (deq_c) begin
         entry_d[head_q].valid = 1'b0;
         head_d                = head_q + PW'(1);
      end

      for (int unsigned i = 0; i < NUM_RESOLVE; i++) begin
         dup_c = 1'b0;
         if (qual_c[i]) begin
            if (|hit_c[i]) begin
               for (int unsigned k = 0; k < DEPTH; k++) begin
                  if (hit_c[i][k]) entry_d[k].target = resolve_target_i[i];
               end
            end else begin
               for (int unsigned j = 0; j < i; j++) begin
                  if (!dup_c && qual_c[j] && (resolve_pc_i[j] == resolve_pc_i[i])) begin
                     dup_c      = 1'b1;
                     alloc_c[i] = alloc_c[j];
                     slot_c[i]  = slot_c[j];
                  end
               end
               // A duplicate of a dropped lane is the same lost update, not another.
               if (dup_c) begin
                  if (alloc_c[i]) entry_d[slot_c[i]].target = resolve_target_i[i];
               end else if (enq_c < free_c) begin
                  slot_c[i]          = tail_q + PW'(enq_c);
                  alloc_c[i]         = 1'b1;
                  entry_d[slot_c[i]] = '{valid: 1'b1, pc: resolve_pc_i[i],
                                         target: resolve_target_i[i]};
                  enq_c              = enq_c + OW'(1);
               end else begin
                  ndrop_c = ndrop_c + DW'(1);
               end
            end
         end
      end

      tail_d     = tail_q + PW'(enq_c);
      occ_d      = occ_q + enq_c - OW'(deq_c);
      drop_sum_c = {1'b0, drop_q} + {1'b0, ndrop_c};
      drop_d     = drop_sum_c[DW] ? '1 : drop_sum_c[DW-1:0];
      wr_valid_c = (occ_d != '0);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         entry_q     <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         occ_q       <= '0;
         drop_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_pc_q     <= '0;
         wr_target_q <= '0;
      end else begin
         entry_q     <= entry_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         occ_q       <= occ_d;
         drop_q      <= drop_d;
         wr_en_q     <= wr_valid_c;
         wr_pc_q     <= wr_valid_c ? entry_d[head_d].pc     : '0;
         wr_target_q <= wr_valid_c ? entry_d[head_d].target : '0;
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_pc_o      = wr_pc_q;
   assign wr_target_o  = wr_target_q;
   assign occupancy_o  = occ_q;
   assign drop_count_o = drop_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue against a queue-based reference model.
module tb_btb_update_queue;

   localparam int DEPTH = 8;
   localparam int NR    = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic [NR-1:0]     rv, rt;
   logic [31:0]       rpc [NR];
   logic [31:0]       rtg [NR];
   logic              wr_en_o;
   logic [31:0]       wr_pc_o, wr_target_o;
   logic [3:0]        occupancy_o;
   logic [15:0]       drop_count_o;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] tgt;
   } ment_t;

   ment_t       mq[$];
   int          mdrop;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] pc_seq = 32'h0001_0000;

   btb_update_queue #(.DEPTH(DEPTH), .NUM_RESOLVE(NR)) dut (
      .clock            (clock),
      .reset            (reset),
      .resolve_valid_i  (rv),
      .resolve_taken_i  (rt),
      .resolve_pc_i     (rpc),
      .resolve_target_i (rtg),
      .wr_en_o          (wr_en_o),
      .wr_pc_o          (wr_pc_o),
      .wr_target_o      (wr_target_o),
      .occupancy_o      (occupancy_o),
      .drop_count_o     (drop_count_o)
   );

   always #5 clock = ~clock;

   // Reference: the queue as a list; head always leaves when non-empty.
   task automatic model_step();
      ment_t       newq[$];
      logic [31:0] dropq[$];
      int          free;
      bit          hit;
      if (reset) begin
         mq.delete();
         mdrop = 0;
         return;
      end
      free = DEPTH - mq.size();
      for (int i = 0; i < NR; i++) begin
         if (rv[i] && rt[i]) begin
            hit = 0;
            for (int k = 1; k < mq.size(); k++)
               if (mq[k].pc == rpc[i]) begin mq[k].tgt = rtg[i]; hit = 1; end
            for (int k = 0; k < newq.size(); k++)
               if (!hit && newq[k].pc == rpc[i]) begin newq[k].tgt = rtg[i]; hit = 1; end
            foreach (dropq[k]) if (dropq[k] == rpc[i]) hit = 1;
            if (!hit) begin
               if (newq.size() < free) newq.push_back('{pc: rpc[i], tgt: rtg[i]});
               else begin mdrop++; dropq.push_back(rpc[i]); end
            end
         end
      end
      if (mq.size() != 0) void'(mq.pop_front());
      foreach (newq[k]) mq.push_back(newq[k]);
      if (mdrop > 16'hFFFF) mdrop = 16'hFFFF;
   endtask

   function automatic logic exp_en();
      return mq.size() != 0;
   endfunction
   function automatic logic [31:0] exp_pc();
      return (mq.size() != 0) ? mq[0].pc : 32'h0;
   endfunction
   function automatic logic [31:0] exp_tgt();
      return (mq.size() != 0) ? mq[0].tgt : 32'h0;
   endfunction

   task automatic idle_lanes();
      rv = '0;
      rt = '0;
      for (int i = 0; i < NR; i++) begin rpc[i] = '0; rtg[i] = '0; end
   endtask

   task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] tgt);
      rv[i] = 1'b1; rt[i] = 1'b1; rpc[i] = pc; rtg[i] = tgt;
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic new_pcs(input int n);
      idle_lanes();
      for (int i = 0; i < n; i++) begin
         set_lane(i, pc_seq, pc_seq ^ 32'hABCD_0000);
         pc_seq = pc_seq + 32'd4;
      end
   endtask

   task automatic test_reset();
      idle_lanes();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (wr_en_o !== 1'b0 || occupancy_o !== 4'd0 || drop_count_o !== 16'd0 ||
             wr_pc_o !== 32'h0 || wr_target_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle c=%0d en=%b occ=%0d drop=%0d pc=%h tgt=%h want all zero",
                     c, wr_en_o, occupancy_o, drop_count_o, wr_pc_o, wr_target_o);
         end
      end
   endtask

   task automatic test_single();
      idle_lanes();
      set_lane(0, 32'h100, 32'h200);
      tick();
      idle_lanes();
      checks++;
      if (wr_en_o !== 1'b1 || wr_pc_o !== 32'h100 || wr_target_o !== 32'h200) begin
         errors++;
         $display("FAIL single_write en=%b pc=%h tgt=%h want 1 100 200", wr_en_o, wr_pc_o, wr_target_o);
      end
      tick();
      checks++;
      if (wr_en_o !== 1'b0 || occupancy_o !== 4'd0) begin
         errors++;
         $display("FAIL single_empty en=%b occ=%0d want 0 0", wr_en_o, occupancy_o);
      end
   endtask

   task automatic test_burst();
      logic [31:0] wq[$];
      int          peak = 0;
      for (int c = 0; c < 16; c++) begin
         idle_lanes();
         if (c < 4) begin
            set_lane(0, 32'h100 + 32'(16 * c),     32'h9000 + 32'(c));
            set_lane(1, 32'h100 + 32'(16 * c + 8), 32'h9100 + 32'(c));
         end
         tick();
         if (wr_en_o === 1'b1) wq.push_back(wr_pc_o);
         if (int'(occupancy_o) > peak) peak = int'(occupancy_o);
         checks++;
         if (wr_en_o !== exp_en() || wr_pc_o !== exp_pc() || wr_target_o !== exp_tgt() ||
             occupancy_o !== 4'(mq.size()) || drop_count_o !== 16'(mdrop)) begin
            errors++;
            $display("FAIL burst c=%0d got en=%b pc=%h tgt=%h occ=%0d drop=%0d want %b %h %h %0d %0d",
                     c, wr_en_o, wr_pc_o, wr_target_o, occupancy_o, drop_count_o,
                     exp_en(), exp_pc(), exp_tgt(), mq.size(), mdrop);
         end
      end
      checks++;
      if (wq.size() != 8 || peak >= 8 || drop_count_o !== 16'd0) begin
         errors++;
         $display("FAIL burst_summary writes=%0d peak=%0d drop=%0d want 8 <8 0", wq.size(), peak, drop_count_o);
      end
      for (int k = 0; k < 8 && k < wq.size(); k++) begin
         checks++;
         if (wq[k] !== 32'h100 + 32'(8 * k)) begin
            errors++;
            $display("FAIL burst_order k=%0d pc=%h want %h", k, wq[k], 32'h100 + 32'(8 * k));
         end
      end
   endtask

   task automatic test_coalesce();
      idle_lanes();
      set_lane(0, 32'h2F0, 32'hAAA);
      set_lane(1, 32'h300, 32'hBBB);
      tick();
      idle_lanes();
      set_lane(0, 32'h300, 32'h500);
      tick();
      idle_lanes();
      checks++;
      if (wr_en_o !== 1'b1 || wr_pc_o !== 32'h300 || wr_target_o !== 32'h500 || occupancy_o !== 4'd1) begin
         errors++;
         $display("FAIL coalesce_entry en=%b pc=%h tgt=%h occ=%0d want 1 300 500 1",
                  wr_en_o, wr_pc_o, wr_target_o, occupancy_o);
      end
      tick();
      set_lane(0, 32'h400, 32'h10);
      set_lane(1, 32'h400, 32'h20);
      tick();
      idle_lanes();
      checks++;
      if (wr_en_o !== 1'b1 || wr_pc_o !== 32'h400 || wr_target_o !== 32'h20 || occupancy_o !== 4'd1) begin
         errors++;
         $display("FAIL coalesce_dup en=%b pc=%h tgt=%h occ=%0d want 1 400 20 1",
                  wr_en_o, wr_pc_o, wr_target_o, occupancy_o);
      end
      tick();
      checks++;
      if (wr_en_o !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_dup_once en=%b want 0", wr_en_o);
      end
   endtask

   task automatic test_overflow();
      idle_lanes();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      new_pcs(4); tick();
      new_pcs(4); tick();
      new_pcs(3); tick();
      checks++;
      if (drop_count_o !== 16'd2 || occupancy_o !== 4'd7) begin
         errors++;
         $display("FAIL overflow_drop drop=%0d occ=%0d want 2 7", drop_count_o, occupancy_o);
      end
      for (int c = 0; c < 22000; c++) begin
         new_pcs(4);
         tick();
         checks++;
         if (wr_en_o !== exp_en() || wr_pc_o !== exp_pc() || wr_target_o !== exp_tgt() ||
             occupancy_o !== 4'(mq.size()) || drop_count_o !== 16'(mdrop)) begin
            errors++;
            $display("FAIL overflow_run c=%0d got en=%b pc=%h occ=%0d drop=%0d want %b %h %0d %0d",
                     c, wr_en_o, wr_pc_o, occupancy_o, drop_count_o,
                     exp_en(), exp_pc(), mq.size(), mdrop);
         end
      end
      checks++;
      if (drop_count_o !== 16'hFFFF) begin
         errors++;
         $display("FAIL overflow_saturate drop=%h want ffff", drop_count_o);
      end
      idle_lanes();
      for (int c = 0; c < 10; c++) tick();
   endtask

   task automatic test_head_race();
      idle_lanes();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_lane(0, 32'h600, 32'h111);
      tick();
      checks++;
      if (wr_en_o !== 1'b1 || wr_pc_o !== 32'h600 || wr_target_o !== 32'h111) begin
         errors++;
         $display("FAIL head_race_old en=%b pc=%h tgt=%h want 1 600 111", wr_en_o, wr_pc_o, wr_target_o);
      end
      set_lane(0, 32'h600, 32'h700);
      tick();
      idle_lanes();
      checks++;
      if (wr_en_o !== 1'b1 || wr_pc_o !== 32'h600 || wr_target_o !== 32'h700 || occupancy_o !== 4'd1) begin
         errors++;
         $display("FAIL head_race_new en=%b pc=%h tgt=%h occ=%0d want 1 600 700 1",
                  wr_en_o, wr_pc_o, wr_target_o, occupancy_o);
      end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 199) == 0);
         rv = NR'($urandom);
         rt = NR'($urandom | $urandom);
         for (int i = 0; i < NR; i++) begin
            rpc[i] = 32'h1000 + 32'(4 * $urandom_range(0, 11));
            rtg[i] = $urandom;
         end
         tick();
         checks++;
         if (wr_en_o !== exp_en() || wr_pc_o !== exp_pc() || wr_target_o !== exp_tgt() ||
             occupancy_o !== 4'(mq.size()) || drop_count_o !== 16'(mdrop)) begin
            errors++;
            $display("FAIL random c=%0d got en=%b pc=%h tgt=%h occ=%0d drop=%0d want %b %h %h %0d %0d",
                     c, wr_en_o, wr_pc_o, wr_target_o, occupancy_o, drop_count_o,
                     exp_en(), exp_pc(), exp_tgt(), mq.size(), mdrop);
         end
      end
      reset = 1'b0;
      idle_lanes();
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      idle_lanes();
      tick();
      reset = 1'b0;
      new_pcs(4); tick();
      new_pcs(2); tick();
      idle_lanes();
      checks++;
      if (occupancy_o !== 4'd5 || wr_en_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_fill occ=%0d en=%b want 5 1", occupancy_o, wr_en_o);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (wr_en_o !== 1'b0 || occupancy_o !== 4'd0 || wr_pc_o !== 32'h0 || drop_count_o !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid en=%b occ=%0d pc=%h drop=%0d want 0 0 0 0",
                  wr_en_o, occupancy_o, wr_pc_o, drop_count_o);
      end
   endtask

   initial begin
      reset = 1'b1;
      mdrop = 0;
      idle_lanes();
      test_reset();
      test_single();
      test_burst();
      test_coalesce();
      test_overflow();
      test_head_race();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
